// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle main controller and the RV32I datapath.
//   i_opcode     : IR[6:0], valid from DECODE onward
//   i_mem_ready  : memory access completes this cycle
//   o_*          : datapath mux selects, write enables, ALU-op, retire pulse, debug state
//   o_illegal    : present only when ILLEGAL_TRAP_EN is defined
// Modports: master = controller, slave = datapath side.
interface multicycle_control_fsm_if;
  logic [6:0] i_opcode;
  logic       i_mem_ready;
  logic       o_pc_write;
  logic       o_branch;
  logic       o_ir_write;
  logic       o_adr_src;
  logic       o_mem_write;
  logic       o_reg_write;
  logic [1:0] o_result_src;
  logic [1:0] o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [2:0] o_aluop;
  logic       o_retire;
  logic [3:0] o_state;
`ifdef ILLEGAL_TRAP_EN
  logic       o_illegal;
`endif

  modport master (
    input  i_opcode, i_mem_ready,
    output o_pc_write, o_branch, o_ir_write, o_adr_src, o_mem_write, o_reg_write,
    output o_result_src, o_alu_src_a, o_alu_src_b, o_aluop, o_retire, o_state
`ifdef ILLEGAL_TRAP_EN
    , output o_illegal
`endif
  );

  modport slave (
    output i_opcode, i_mem_ready,
    input  o_pc_write, o_branch, o_ir_write, o_adr_src, o_mem_write, o_reg_write,
    input  o_result_src, o_alu_src_a, o_alu_src_b, o_aluop, o_retire, o_state
`ifdef ILLEGAL_TRAP_EN
    , input o_illegal
`endif
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore-style main controller for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over the shared ALU, memory port and
// register file.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   io_bus   : multicycle_control_fsm_if.master (opcode/ready in, datapath controls out)
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes in state TRAP (11) and
// expose o_illegal; otherwise unknown opcodes retire as a NOP from DECODE.
module multicycle_control_fsm #(
  parameter logic [6:0] R_TYPE = 7'b0110011,
  parameter logic [6:0] I_TYPE = 7'b0010011,
  parameter logic [6:0] LOAD   = 7'b0000011,
  parameter logic [6:0] STORE  = 7'b0100011,
  parameter logic [6:0] BRANCH = 7'b1100011,
  parameter logic [6:0] JAL    = 7'b1101111
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  multicycle_control_fsm_if.master        io_bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJals     = 4'd10
`ifdef ILLEGAL_TRAP_EN
    , StTrap   = 4'd11
`endif
  } state_e;

  // Moore part of the control word, registered alongside the state.
  typedef struct packed {
    logic       fetch;      // ir/pc write, still gated by i_mem_ready
    logic       jump;       // unconditional pc load (jal)
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'd2;
        c.result_src = 2'd2;
      end
      StDecode: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd1;
      end
      StMemAdr: begin
        c.alu_src_a = 2'd2;
        c.alu_src_b = 2'd1;
      end
      StMemRead:  c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = 2'd1;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      StExecR: begin
        c.alu_src_a = 2'd2;
        c.aluop     = 3'd2;
      end
      StExecI: begin
        c.alu_src_a = 2'd2;
        c.alu_src_b = 2'd1;
        c.aluop     = 3'd2;
      end
      StAluWb:    c.reg_write = 1'b1;
      StBeq: begin
        c.alu_src_a = 2'd2;
        c.aluop     = 3'd1;
        c.branch    = 1'b1;
      end
      StJals: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd2;
        c.jump      = 1'b1;
      end
      default: c = '0;  // unused codes and TRAP: everything off
    endcase
    return c;
  endfunction

  state_e     r_state;
  ctrl_t      r_ctrl;
  state_e     w_state_d;
  logic       w_retire;
  logic [6:0] w_opcode;

  assign w_opcode = io_bus.i_opcode;

  always_comb begin
    w_state_d = StFetch;
    case (r_state)
      StFetch:  w_state_d = io_bus.i_mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (w_opcode)
          LOAD, STORE: w_state_d = StMemAdr;
          R_TYPE:      w_state_d = StExecR;
          I_TYPE:      w_state_d = StExecI;
          BRANCH:      w_state_d = StBeq;
          JAL:         w_state_d = StJals;
`ifdef ILLEGAL_TRAP_EN
          default:     w_state_d = StTrap;
`else
          default:     w_state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: begin
        if (w_opcode == LOAD) begin
          w_state_d = StMemRead;
        end else if (w_opcode == STORE) begin
          w_state_d = StMemWrite;
        end else begin
          w_state_d = StFetch;
        end
      end
      StMemRead:  w_state_d = io_bus.i_mem_ready ? StMemWb : StMemRead;
      StMemWb:    w_state_d = StFetch;
      StMemWrite: w_state_d = io_bus.i_mem_ready ? StFetch : StMemWrite;
      StExecR:    w_state_d = StAluWb;
      StExecI:    w_state_d = StAluWb;
      StAluWb:    w_state_d = StFetch;
      StBeq:      w_state_d = StFetch;
      StJals:     w_state_d = StAluWb;
`ifdef ILLEGAL_TRAP_EN
      StTrap:     w_state_d = StTrap;   // sticky until reset
`endif
      default:    w_state_d = StFetch;
    endcase
  end

  // Control word is decoded from the next state so it lines up with r_state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StFetch;
      r_ctrl  <= ctrl_decode(StFetch);
    end else begin
      r_state <= w_state_d;
      r_ctrl  <= ctrl_decode(w_state_d);
    end
  end

  // Retire marks the final cycle of an instruction; depends on ready/opcode in this cycle.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      StMemWb, StAluWb, StBeq: w_retire = 1'b1;
      StMemWrite:              w_retire = io_bus.i_mem_ready;
`ifndef ILLEGAL_TRAP_EN
      StDecode: begin
        case (w_opcode)
          LOAD, STORE, R_TYPE, I_TYPE, BRANCH, JAL: w_retire = 1'b0;
          default:                                  w_retire = 1'b1;
        endcase
      end
`endif
      default:                 w_retire = 1'b0;
    endcase
  end

  // Enables are masked while reset is asserted so an abandoned access writes nothing.
  assign io_bus.o_ir_write   = i_rst_n & r_ctrl.fetch & io_bus.i_mem_ready;
  assign io_bus.o_pc_write   = i_rst_n & ((r_ctrl.fetch & io_bus.i_mem_ready) | r_ctrl.jump);
  assign io_bus.o_branch     = i_rst_n & r_ctrl.branch;
  assign io_bus.o_mem_write  = i_rst_n & r_ctrl.mem_write;
  assign io_bus.o_reg_write  = i_rst_n & r_ctrl.reg_write;
  assign io_bus.o_retire     = i_rst_n & w_retire;
  assign io_bus.o_adr_src    = r_ctrl.adr_src;
  assign io_bus.o_result_src = r_ctrl.result_src;
  assign io_bus.o_alu_src_a  = r_ctrl.alu_src_a;
  assign io_bus.o_alu_src_b  = r_ctrl.alu_src_b;
  assign io_bus.o_aluop      = r_ctrl.aluop;
  assign io_bus.o_state      = r_state;
`ifdef ILLEGAL_TRAP_EN
  assign io_bus.o_illegal    = (r_state == StTrap);
`endif

endmodule
